facto_core: RTL and testbench

- Memory-mapped factorial accelerator; slave s1 on the 64-bit system bus, downstream of the bus block.
- Accepts N through register writes and iteratively computes N! into a 128-bit result, using one shift-add multiply per factor.
- Raises opdone and an optional interrupt when finished.
- Read data is registered one cycle after the access, matching the bus's registered read-mux timing.

---
 rtl/facto_core_pkg.sv | 29 ++
 rtl/facto_core_mul_shift_add.sv | 76 +++++++
 rtl/facto_core.sv | 197 +++++++++++++++++++
 tb/tb_facto_core.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/facto_core_pkg.sv
// -----------------------------------------------------------------------------
// facto_core_pkg
// Shared constants for the factorial accelerator: bus/datapath widths,
// multiply latency, register offsets and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package facto_core_pkg;

    localparam int DATA_W     = 64;   // bus data width and multiplier width
    localparam int ADDR_W     = 16;   // bus address width
    localparam int MUL_CYCLES = 64;   // one multiplier bit per cycle

    // Register offsets (s_addr[7:0])
    localparam logic [7:0] OFF_OPSTART  = 8'h00;
    localparam logic [7:0] OFF_OPCLEAR  = 8'h08;
    localparam logic [7:0] OFF_OPDONE   = 8'h10;
    localparam logic [7:0] OFF_INTREN   = 8'h18;
    localparam logic [7:0] OFF_OPERAND  = 8'h20;
    localparam logic [7:0] OFF_RESULT_H = 8'h28;
    localparam logic [7:0] OFF_RESULT_L = 8'h30;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage : facto_core_pkg

// File: rtl/facto_core_mul_shift_add.sv
// -----------------------------------------------------------------------------
// mul_shift_add
// Radix-2 shift-add multiplier: 128-bit multiplicand x 64-bit multiplier,
// product truncated to 128 bits. Bit 0 of the multiplier is consumed on the
// start edge itself, so the full product is ready after exactly MUL_CYCLES
// edges (start edge included) and o_done pulses for one cycle right after.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   i_start    in   load operands and begin a multiply
//   i_abort    in   drop any multiply in progress
//   i_mcand    in   2*DATA_W multiplicand
//   i_mplier   in   DATA_W multiplier
//   o_product  out  2*DATA_W product (valid when o_done=1, held afterwards)
//   o_done     out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module mul_shift_add
    import facto_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [2*DATA_W-1:0]   i_mcand,
    input  logic [DATA_W-1:0]     i_mplier,
    output logic [2*DATA_W-1:0]   o_product,
    output logic                  o_done
);

    localparam int               CNT_W    = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MUL_CYCLES - 1);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mc;     // multiplicand, pre-shifted to current bit weight
    logic [DATA_W-1:0]   r_mp;     // remaining multiplier bits, LSB is next
    logic [CNT_W-1:0]    r_bit;    // index of the bit processed on the next edge
    logic                r_busy;
    logic                r_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain updates within
    // one edge and break the shift/accumulate ordering.
    always_ff @(posedge clk) begin
        if (reset || i_abort) begin
            r_acc  <= '0;
            r_mc   <= '0;
            r_mp   <= '0;
            r_bit  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_acc  <= i_mplier[0] ? i_mcand : '0;
            r_mc   <= i_mcand << 1;
            r_mp   <= i_mplier >> 1;
            r_bit  <= CNT_W'(1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            if (r_mp[0]) begin
                r_acc <= r_acc + r_mc;
            end
            r_mc   <= r_mc << 1;
            r_mp   <= r_mp >> 1;
            r_bit  <= r_bit + CNT_W'(1);
            r_busy <= (r_bit != LAST_BIT);
            r_done <= (r_bit == LAST_BIT);
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_product = r_acc;
    assign o_done    = r_done;

endmodule : mul_shift_add

// File: rtl/facto_core.sv
// -----------------------------------------------------------------------------
// facto_core
// Memory-mapped factorial accelerator (bus slave). Software writes N to
// operand and sets opstart; the core computes N! (mod 2^128) with one
// shift-add multiply per factor, then reports opdone and optionally raises
// an interrupt. Read data is registered: valid one cycle after the access.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   s_sel      in   slave select
//   s_wr       in   1=write, 0=read
//   s_addr     in   byte address, offset = s_addr[7:0]
//   s_din      in   write data
//   s_dout     out  registered read data (0 when no read)
//   interrupt  out  opdone[0] & intrEn[0]
// -----------------------------------------------------------------------------
module facto_core
    import facto_core_pkg::*;
#(
    parameter int DATA_W = facto_core_pkg::DATA_W,
    parameter int ADDR_W = facto_core_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              interrupt
);

    localparam logic [2*DATA_W-1:0] RESULT_ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   ONE        = {{(DATA_W-1){1'b0}}, 1'b1};

    // ---------------- registers ----------------
    state_e              r_state;
    logic                r_opstart;
    logic                r_intr_en;
    logic [DATA_W-1:0]   r_operand;
    logic [DATA_W-1:0]   r_cnt;
    logic [2*DATA_W-1:0] r_result;

    // ---------------- bus decode ----------------
    logic [7:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic       w_start_req;
    logic       w_clear;
    logic       w_unused;

    assign w_off       = s_addr[7:0];
    assign w_wr        = s_sel &  s_wr;
    assign w_rd        = s_sel & ~s_wr;
    assign w_start_req = w_wr && (w_off == OFF_OPSTART) && s_din[0];
    assign w_clear     = w_wr && (w_off == OFF_OPCLEAR) && s_din[0];
    assign w_unused    = ^s_addr[ADDR_W-1:8];

    // ---------------- multiplier ----------------
    state_e              w_next;
    logic                w_busy;
    logic                w_done;
    logic                w_mul_start;
    logic                w_mul_done;
    logic [2*DATA_W-1:0] w_mcand;
    logic [DATA_W-1:0]   w_mplier;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_cnt_dec;
    logic                w_last_factor;

    assign w_cnt_dec     = r_cnt - ONE;
    assign w_last_factor = (w_cnt_dec == ONE);

    mul_shift_add u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_abort   (w_clear),
        .i_mcand   (w_mcand),
        .i_mplier  (w_mplier),
        .o_product (w_product),
        .o_done    (w_mul_done)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        if (w_clear) begin
            w_next = S_IDLE;            // clear wins over any other event
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_req) w_next = S_INIT;
                S_INIT:  w_next = (r_operand <= ONE) ? S_DONE : S_MUL;
                S_MUL:   if (w_mul_done) w_next = w_last_factor ? S_DONE : S_MUL;
                S_DONE:  w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // The next multiply is launched on the same edge the previous one is
    // consumed, fed combinationally with the fresh product and cnt-1, so
    // each factor costs exactly MUL_CYCLES edges.
    always_comb begin
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_mul_start = 1'b0;
        w_mcand     = w_product;
        w_mplier    = w_cnt_dec;
        case (r_state)
            S_INIT: begin
                w_busy      = 1'b1;
                w_mcand     = RESULT_ONE;
                w_mplier    = r_operand;
                w_mul_start = !w_clear && (r_operand > ONE);
            end
            S_MUL: begin
                w_busy      = 1'b1;
                w_mul_start = !w_clear && w_mul_done && !w_last_factor;
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- read mux ----------------
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_OPSTART:  w_rdata = {{(DATA_W-1){1'b0}}, r_opstart};
            OFF_OPDONE:   w_rdata = {{(DATA_W-2){1'b0}}, w_busy, w_done};
            OFF_INTREN:   w_rdata = {{(DATA_W-1){1'b0}}, r_intr_en};
            OFF_OPERAND:  w_rdata = r_operand;
            OFF_RESULT_H: w_rdata = r_result[2*DATA_W-1:DATA_W];
            OFF_RESULT_L: w_rdata = r_result[DATA_W-1:0];
            default:      w_rdata = '0;   // opclear and unmapped offsets
        endcase
    end

    // ---------------- datapath / register file ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opstart <= 1'b0;
            r_intr_en <= 1'b0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            s_dout    <= '0;
        end else begin
            if (w_clear) begin
                r_opstart <= 1'b0;
                r_cnt     <= '0;
                r_result  <= '0;
            end else begin
                if (r_state == S_IDLE && w_start_req) begin
                    r_opstart <= 1'b1;
                end
                if (r_state == S_INIT) begin
                    r_result <= RESULT_ONE;
                    r_cnt    <= r_operand;
                end
                if (r_state == S_MUL && w_mul_done) begin
                    r_result <= w_product;
                    r_cnt    <= w_cnt_dec;
                end
            end

            // operand is frozen while a computation is using it
            if (w_wr && w_off == OFF_OPERAND && !w_busy) begin
                r_operand <= s_din;
            end
            if (w_wr && w_off == OFF_INTREN) begin
                r_intr_en <= s_din[0];
            end

            s_dout <= w_rd ? w_rdata : '0;
        end
    end

    assign interrupt = w_done & r_intr_en;

endmodule : facto_core

// File: tb/tb_facto_core.sv
// -----------------------------------------------------------------------------
// tb_facto_core
// Self-checking bench for facto_core. Reads queue their expected data; a
// monitor pops and compares one cycle after each read. Expected values come
// from directed constants or from a timing/arithmetic model of the register
// map (start edge, 64 cycles per factor, partial products N*(N-1)*...).
// -----------------------------------------------------------------------------
module tb_facto_core;
    import facto_core_pkg::*;

    localparam int DW = 64;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_sel;
    logic          s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic [DW-1:0] s_dout;
    logic          interrupt;

    facto_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    longint unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  off;
        logic [63:0] val;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_started;
    bit              m_intr;
    logic [63:0]     m_operand;
    longint unsigned m_t0;
    longint unsigned m_n;

    function automatic longint unsigned done_edge();
        return (m_n <= 1) ? m_t0 + 1 : m_t0 + 1 + 64 * (m_n - 1);
    endfunction

    // opdone value once 'a' clock edges have occurred
    function automatic logic [1:0] opdone_after(input longint unsigned a);
        if (!m_started) return 2'b00;
        return (a < done_edge()) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [127:0] result_after(input longint unsigned a);
        logic [127:0]    r;
        longint unsigned k;
        if (!m_started || a < m_t0 + 1) return '0;
        if (m_n <= 1) return 128'd1;
        k = (a - m_t0 - 1) / 64;
        if (k > m_n - 1) k = m_n - 1;
        r = 128'd1;
        for (longint unsigned i = 0; i < k; i++) r = r * 128'(m_n - i);
        return r;
    endfunction

    function automatic logic [63:0] exp_reg(input logic [7:0] off, input longint unsigned a);
        logic [127:0] res;
        logic [1:0]   od;
        res = result_after(a);
        od  = opdone_after(a);
        case (off)
            OFF_OPSTART:  return {63'd0, m_started};
            OFF_OPDONE:   return {62'd0, od};
            OFF_INTREN:   return {63'd0, m_intr};
            OFF_OPERAND:  return m_operand;
            OFF_RESULT_H: return res[127:64];
            OFF_RESULT_L: return res[63:0];
            default:      return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_intr    = 0;
        m_operand = '0;
        m_t0      = 0;
        m_n       = 0;
    endtask

    // ---------------- bus driver ----------------
    task automatic drive(input logic wr, input logic [7:0] off, input logic [63:0] d);
        s_sel  = 1'b1;
        s_wr   = wr;
        s_addr = {8'($urandom), off};
        s_din  = d;
        @(negedge clk);
        s_sel  = 1'b0;
        s_wr   = 1'b0;
        s_din  = '0;
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [63:0] d);
        longint unsigned e;
        logic [1:0]      od;
        e  = edge_n + 1;
        od = opdone_after(edge_n);
        case (off)
            OFF_OPSTART: if (d[0] && !m_started) begin
                m_started = 1;
                m_t0      = e;
                m_n       = longint'(m_operand);
            end
            OFF_OPCLEAR: if (d[0]) m_started = 0;
            OFF_INTREN:  m_intr = d[0];
            OFF_OPERAND: if (od != 2'b10) m_operand = d;
            default: ;
        endcase
        drive(1'b1, off, d);
    endtask

    task automatic bus_read(input logic [7:0] off);
        rd_exp_t x;
        x.off = off;
        x.val = exp_reg(off, edge_n);
        exp_q.push_back(x);
        drive(1'b0, off, 64'($urandom));
    endtask

    task automatic bus_read_exp(input logic [7:0] off, input logic [63:0] val);
        rd_exp_t x;
        x.off = off;
        x.val = val;
        exp_q.push_back(x);
        drive(1'b0, off, 64'($urandom));
    endtask

    task automatic idle_until(input longint unsigned a);
        while (edge_n < a) @(negedge clk);
    endtask

    task automatic chk_intr(input string name);
        logic [1:0] od;
        od = opdone_after(edge_n);
        check(name, interrupt, od[0] & m_intr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic    rd;
        rd_exp_t x;
        forever begin
            @(posedge clk);
            rd = s_sel && !s_wr && !reset;
            #1;
            if (rd) begin
                if (exp_q.size() == 0) begin
                    check("read_without_expectation", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    check($sformatf("read off=%02h", x.off), s_dout, x.val);
                end
            end else begin
                check("dout_zero_without_read", s_dout, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] offs [9] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hF8};

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1'b1;
        s_sel  = 1'b0;
        s_wr   = 1'b0;
        s_addr = '0;
        s_din  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state: every offset reads 0
        foreach (offs[i]) bus_read_exp(offs[i], 64'd0);
        check("intr_after_reset", interrupt, 0);

        // N=5 with interrupt enabled
        bus_write(OFF_OPERAND, 64'd5);
        bus_write(OFF_INTREN, 64'd1);
        bus_write(OFF_OPSTART, 64'd1);
        bus_read_exp(OFF_OPDONE, 64'h2);
        chk_intr("intr_busy_n5");
        idle_until(m_t0 + 256);
        bus_read_exp(OFF_OPDONE, 64'h2);          // one edge before done
        bus_read_exp(OFF_OPDONE, 64'h1);          // start + 257
        check("intr_done_n5", interrupt, 1);
        bus_read_exp(OFF_RESULT_L, 64'h78);
        bus_read_exp(OFF_RESULT_H, 64'h0);
        bus_read_exp(OFF_OPSTART, 64'h1);

        // N=0 and N=1: done one cycle after start
        for (int n = 0; n < 2; n++) begin
            bus_write(OFF_OPCLEAR, 64'd1);
            check("intr_clear_edge", interrupt, 0);
            bus_read_exp(OFF_OPCLEAR, 64'd0);
            bus_read_exp(OFF_OPDONE, 64'd0);
            bus_write(OFF_OPERAND, 64'(n));
            bus_write(OFF_OPSTART, 64'd1);
            bus_read_exp(OFF_OPDONE, 64'h2);      // INIT
            bus_read_exp(OFF_OPDONE, 64'h1);
            bus_read_exp(OFF_RESULT_L, 64'd1);
            bus_read_exp(OFF_RESULT_H, 64'd0);
        end

        // N=21 (crosses 64 bits); operand and opstart writes while busy ignored
        bus_write(OFF_OPCLEAR, 64'd1);
        bus_write(OFF_OPERAND, 64'd21);
        bus_write(OFF_OPSTART, 64'd1);
        bus_write(OFF_OPERAND, 64'd3);
        bus_write(OFF_OPSTART, 64'd1);
        bus_read_exp(OFF_OPERAND, 64'd21);
        idle_until(done_edge());
        bus_read_exp(OFF_RESULT_H, 64'h2);
        bus_read_exp(OFF_RESULT_L, 64'hC5077D36B8C40000);

        // N=10 aborted 100 cycles after start, then rerun
        bus_write(OFF_OPCLEAR, 64'd1);
        bus_write(OFF_OPERAND, 64'd10);
        bus_write(OFF_OPSTART, 64'd1);
        idle_until(m_t0 + 99);
        bus_write(OFF_OPCLEAR, 64'd1);
        bus_read_exp(OFF_OPDONE, 64'd0);
        bus_read_exp(OFF_RESULT_L, 64'd0);
        bus_read_exp(OFF_RESULT_H, 64'd0);
        bus_read_exp(OFF_OPERAND, 64'd10);
        bus_read_exp(OFF_OPSTART, 64'd0);
        check("intr_after_abort", interrupt, 0);
        bus_write(OFF_OPSTART, 64'd1);
        idle_until(done_edge());
        bus_read_exp(OFF_RESULT_L, 64'h375F00);

        // reset in the middle of a multiply, then a run with interrupts off
        bus_write(OFF_OPCLEAR, 64'd1);
        bus_write(OFF_OPERAND, 64'd6);
        bus_write(OFF_OPSTART, 64'd1);
        idle_until(m_t0 + 150);
        do_reset();
        check("intr_after_mid_reset", interrupt, 0);
        check("dout_after_mid_reset", s_dout, 0);
        foreach (offs[i]) bus_read_exp(offs[i], 64'd0);
        bus_write(OFF_OPERAND, 64'd4);
        bus_write(OFF_OPSTART, 64'd1);
        idle_until(done_edge());
        bus_read_exp(OFF_OPDONE, 64'h1);
        check("intr_masked", interrupt, 0);
        bus_read_exp(OFF_RESULT_L, 64'd24);

        // randomized runs against the model
        for (int run = 0; run < 8; run++) begin
            int unsigned n;
            n = $urandom_range(0, 9);
            bus_write(OFF_OPCLEAR, 64'd1);
            bus_write(OFF_INTREN, 64'($urandom_range(0, 1)));
            bus_write(OFF_OPERAND, 64'(n));
            bus_write(OFF_OPSTART, 64'd1);
            while (edge_n < done_edge() + 3) begin
                case ($urandom_range(0, 4))
                    0, 1: bus_read(offs[$urandom_range(0, 8)]);
                    2:    repeat ($urandom_range(1, 40)) @(negedge clk);
                    3:    bus_write(OFF_OPERAND, 64'($urandom_range(0, 30)));
                    default: bus_write(OFF_OPSTART, 64'd1);
                endcase
                chk_intr("intr_random");
            end
            bus_read(OFF_OPDONE);
            bus_read(OFF_RESULT_L);
            bus_read(OFF_RESULT_H);
            bus_read(OFF_OPERAND);
        end

        repeat (3) @(negedge clk);
        check("expectations_drained", 128'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_facto_core
